// File: rtl/button_sync_debounce_pkg.sv
// Shared constants and helpers for the push-button front end.
// Optional build macro: FALL_PULSE_EN adds a falling-edge pulse output per channel.
package button_sync_pkg;

    // Default configuration of the synchroniser / debounce path
    localparam int DEF_SYNC_STAGES     = 32'sd2;
    localparam int DEF_DEBOUNCE_CYCLES = 32'sd16;

    // Channel assignment used by the clip-recorder control FSM
    localparam int CH_RESET   = 32'sd0;
    localparam int CH_CLIP    = 32'sd1;
    localparam int CH_PLAYREC = 32'sd2;
    localparam int CH_ACTION  = 32'sd3;

    // Width of the stability counter; it only has to reach cycles-1,
    // and never drops below one bit so the vector stays legal.
    function automatic int cnt_w(input int cycles);
        if (cycles <= 32'sd1) begin
            return 32'sd1;
        end else begin
            return $clog2(cycles);
        end
    endfunction

endpackage

// File: rtl/button_sync_debounce_if.sv
// Button bundle between the raw pins and the control FSM.
// Optional build macro: FALL_PULSE_EN adds buttonsFall.
interface button_sync_debounce_if #(
    parameter int NUM_CH = 32'sd4
) ();

    logic [NUM_CH-1:0] buttonsIn;
    logic [NUM_CH-1:0] buttonsLevel;
    logic [NUM_CH-1:0] buttonsRise;
`ifdef FALL_PULSE_EN
    logic [NUM_CH-1:0] buttonsFall;
`endif

    // Pin side: drives the raw inputs, observes the cleaned outputs
    modport master (
        output buttonsIn,
        input  buttonsLevel,
        input  buttonsRise
`ifdef FALL_PULSE_EN
        ,
        input  buttonsFall
`endif
    );

    // Debouncer side
    modport slave (
        input  buttonsIn,
        output buttonsLevel,
        output buttonsRise
`ifdef FALL_PULSE_EN
        ,
        output buttonsFall
`endif
    );

endinterface

// File: rtl/button_sync_debounce_channel.sv
// One button channel: synchroniser chain, stability counter, level and edge pulses.
// Optional build macro: FALL_PULSE_EN adds the registered falling-edge pulse.
module debounce_channel
    import button_sync_pkg::*;
#(
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clock,
    input  logic reset,
    input  logic button_i,
    output logic level_o,
    output logic rise_o
`ifdef FALL_PULSE_EN
    ,
    output logic fall_o
`endif
);

    localparam int               CNT_W   = cnt_w(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 32'sd1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   syncd_s;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       cnt_d;
    logic                   level_q;
    logic                   level_d;
    logic                   rise_q;
    logic                   rise_d;
`ifdef FALL_PULSE_EN
    logic                   fall_q;
    logic                   fall_d;
`endif

    // Shift the raw pin into the synchroniser; only stage 0 ever sees button_i
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], button_i};
    end

    assign syncd_s = sync_q[SYNC_STAGES-1];

    // Stability counter: any agreement with the current level clears the count,
    // the level flips only after DEBOUNCE_CYCLES consecutive disagreeing cycles
    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        if (syncd_s == level_q) begin
            cnt_d = {CNT_W{1'b0}};
        end else if (cnt_q == CNT_MAX) begin
            level_d = syncd_s;
            cnt_d   = {CNT_W{1'b0}};
        end else begin
            cnt_d = cnt_q + CNT_W'(1'b1);
        end
    end

    // Edge pulses derive from the level about to be registered, so they
    // appear on the same edge as the level change and last one cycle
    always_comb begin
        rise_d = level_d & ~level_q;
`ifdef FALL_PULSE_EN
        fall_d = ~level_d & level_q;
`endif
    end

    // State and output registers; reset drops everything, including partial counts
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_q  <= {SYNC_STAGES{1'b0}};
            cnt_q   <= {CNT_W{1'b0}};
            level_q <= 1'b0;
            rise_q  <= 1'b0;
`ifdef FALL_PULSE_EN
            fall_q  <= 1'b0;
`endif
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
`ifdef FALL_PULSE_EN
            fall_q  <= fall_d;
`endif
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;
`ifdef FALL_PULSE_EN
    assign fall_o  = fall_q;
`endif

endmodule

// File: rtl/button_sync_debounce.sv
// Multi-channel push-button synchroniser and debouncer for the clip-recorder front end.
// Optional build macro: FALL_PULSE_EN adds buttonsFall (one-cycle 1->0 pulse).
module button_sync_debounce
    import button_sync_pkg::*;
#(
    parameter int NUM_CH          = 32'sd4,
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic                   clock,
    input  logic                   reset,
    button_sync_debounce_if.slave  bus
);

    // Reject configurations the channel logic cannot implement
    if (NUM_CH < 32'sd1) begin : g_bad_num_ch
        $error("button_sync_debounce: NUM_CH must be >= 1");
    end
    if (SYNC_STAGES < 32'sd2) begin : g_bad_sync
        $error("button_sync_debounce: SYNC_STAGES must be >= 2");
    end
    if (DEBOUNCE_CYCLES < 32'sd1) begin : g_bad_deb
        $error("button_sync_debounce: DEBOUNCE_CYCLES must be >= 1");
    end

    logic [NUM_CH-1:0] level_s;
    logic [NUM_CH-1:0] rise_s;
`ifdef FALL_PULSE_EN
    logic [NUM_CH-1:0] fall_s;
`endif

    // Channels share nothing but the clock and reset
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        debounce_channel #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_ch (
            .clock    (clock),
            .reset    (reset),
            .button_i (bus.buttonsIn[i]),
            .level_o  (level_s[i]),
            .rise_o   (rise_s[i])
`ifdef FALL_PULSE_EN
            ,
            .fall_o   (fall_s[i])
`endif
        );
    end

    assign bus.buttonsLevel = level_s;
    assign bus.buttonsRise  = rise_s;
`ifdef FALL_PULSE_EN
    assign bus.buttonsFall  = fall_s;
`endif

endmodule

// File: tb/tb_button_sync_debounce.sv
// Self-checking bench for button_sync_debounce: four configurations side by side,
// hand sequences for the timing corner cases, a vector table for the
// no-filter build and randomized stimulus against a window-based reference model.
module tb_button_sync_debounce;
    import button_sync_pkg::*;

    localparam int NDUT = 4;
    localparam int HL   = 24;
    localparam int S_P [NDUT] = '{2, 2, 3, 3};
    localparam int D_P [NDUT] = '{16, 4, 1, 1};
    localparam int W_P [NDUT] = '{4, 4, 8, 1};

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    logic [7:0] in_v   [NDUT];
    logic [7:0] lvl_o  [NDUT];
    logic [7:0] rise_o [NDUT];
    logic [7:0] fall_o [NDUT];

    int   total = 0;
    int   bad   = 0;
    logic chk_en = 1'b0;
    int   hold [NDUT];

    button_sync_debounce_if #(.NUM_CH(4)) if_a ();
    button_sync_debounce_if #(.NUM_CH(4)) if_b ();
    button_sync_debounce_if #(.NUM_CH(8)) if_c ();
    button_sync_debounce_if #(.NUM_CH(1)) if_d ();

    button_sync_debounce #(.NUM_CH(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(16))
        u_a (.clock(clock), .reset(reset), .bus(if_a));
    button_sync_debounce #(.NUM_CH(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4))
        u_b (.clock(clock), .reset(reset), .bus(if_b));
    button_sync_debounce #(.NUM_CH(8), .SYNC_STAGES(3), .DEBOUNCE_CYCLES(1))
        u_c (.clock(clock), .reset(reset), .bus(if_c));
    button_sync_debounce #(.NUM_CH(1), .SYNC_STAGES(3), .DEBOUNCE_CYCLES(1))
        u_d (.clock(clock), .reset(reset), .bus(if_d));

    assign if_a.buttonsIn = in_v[0][3:0];
    assign if_b.buttonsIn = in_v[1][3:0];
    assign if_c.buttonsIn = in_v[2];
    assign if_d.buttonsIn = in_v[3][0];

    assign lvl_o[0]  = {4'b0, if_a.buttonsLevel};
    assign lvl_o[1]  = {4'b0, if_b.buttonsLevel};
    assign lvl_o[2]  = if_c.buttonsLevel;
    assign lvl_o[3]  = {7'b0, if_d.buttonsLevel};
    assign rise_o[0] = {4'b0, if_a.buttonsRise};
    assign rise_o[1] = {4'b0, if_b.buttonsRise};
    assign rise_o[2] = if_c.buttonsRise;
    assign rise_o[3] = {7'b0, if_d.buttonsRise};
`ifdef FALL_PULSE_EN
    assign fall_o[0] = {4'b0, if_a.buttonsFall};
    assign fall_o[1] = {4'b0, if_b.buttonsFall};
    assign fall_o[2] = if_c.buttonsFall;
    assign fall_o[3] = {7'b0, if_d.buttonsFall};
`else
    assign fall_o[0] = 8'h00;
    assign fall_o[1] = 8'h00;
    assign fall_o[2] = 8'h00;
    assign fall_o[3] = 8'h00;
`endif

    function automatic logic [7:0] mask_of(input int w);
        return 8'hFF >> (8 - w);
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h time=%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clock);
    endtask

    // Reference model: the level of a channel flips when the last D synchronised
    // samples (the input as seen S edges late) all disagree with it.
    logic [7:0] hist_m [NDUT][HL];
    logic [7:0] lvl_m  [NDUT];
    logic [7:0] rise_m [NDUT];
    logic [7:0] fall_m [NDUT];

    always @(posedge clock or negedge reset) begin : model
        logic [7:0] diff;
        if (!reset) begin
            for (int d = 0; d < NDUT; d++) begin
                for (int j = 0; j < HL; j++) hist_m[d][j] <= 8'h00;
                lvl_m[d]  <= 8'h00;
                rise_m[d] <= 8'h00;
                fall_m[d] <= 8'h00;
            end
        end else begin
            for (int d = 0; d < NDUT; d++) begin
                diff = mask_of(W_P[d]);
                for (int j = S_P[d] - 1; j <= S_P[d] + D_P[d] - 2; j++)
                    diff = diff & (hist_m[d][j] ^ lvl_m[d]);
                lvl_m[d]  <= lvl_m[d] ^ diff;
                rise_m[d] <= diff & ~lvl_m[d];
                fall_m[d] <= diff & lvl_m[d];
                for (int j = HL - 1; j > 0; j--) hist_m[d][j] <= hist_m[d][j-1];
                hist_m[d][0] <= in_v[d];
            end
        end
    end

    // Continuous comparison against the model, away from the active edge
    always @(negedge clock) begin
        if (chk_en) begin
            for (int d = 0; d < NDUT; d++) begin
                check($sformatf("mdl_lvl%0d", d), lvl_o[d], lvl_m[d]);
                check($sformatf("mdl_rise%0d", d), rise_o[d], rise_m[d]);
`ifdef FALL_PULSE_EN
                check($sformatf("mdl_fall%0d", d), fall_o[d], fall_m[d]);
`endif
            end
        end
    end

    typedef struct {
        logic [7:0] in;
        logic [7:0] lvl;
        logic [7:0] rise;
        logic [7:0] fall;
    } vec_t;

    vec_t tbl [13];

    initial begin
        // No-filter build, S=3 D=1: level after edge k equals the input applied 3 rows earlier
        tbl[0]  = '{8'hA5, 8'h00, 8'h00, 8'h00};
        tbl[1]  = '{8'hA5, 8'h00, 8'h00, 8'h00};
        tbl[2]  = '{8'hFF, 8'h00, 8'h00, 8'h00};
        tbl[3]  = '{8'h00, 8'hA5, 8'hA5, 8'h00};
        tbl[4]  = '{8'h00, 8'hA5, 8'h00, 8'h00};
        tbl[5]  = '{8'h3C, 8'hFF, 8'h5A, 8'h00};
        tbl[6]  = '{8'h3C, 8'h00, 8'h00, 8'hFF};
        tbl[7]  = '{8'h3C, 8'h00, 8'h00, 8'h00};
        tbl[8]  = '{8'h3C, 8'h3C, 8'h3C, 8'h00};
        tbl[9]  = '{8'h00, 8'h3C, 8'h00, 8'h00};
        tbl[10] = '{8'h00, 8'h3C, 8'h00, 8'h00};
        tbl[11] = '{8'h00, 8'h3C, 8'h00, 8'h00};
        tbl[12] = '{8'h00, 8'h00, 8'h00, 8'h3C};

        for (int d = 0; d < NDUT; d++) in_v[d] = 8'hFF;
        #1 reset = 1'b0;
        #2 chk_en = 1'b1;

        // Reset held with all inputs high: outputs stay 0
        repeat (5) begin
            tick();
            check("rst_hold_lvl", lvl_o[0], 8'h00);
            check("rst_hold_rise", rise_o[0], 8'h00);
        end
        #2 reset = 1'b1;

        // Release: level comes up on edge 18 with a single rise pulse
        for (int k = 1; k <= 19; k++) begin
            tick();
            check($sformatf("rel_lvl_e%0d", k), lvl_o[0], (k >= 18) ? 8'h0F : 8'h00);
            check($sformatf("rel_rise_e%0d", k), rise_o[0], (k == 18) ? 8'h0F : 8'h00);
        end

        for (int d = 0; d < NDUT; d++) in_v[d] = 8'h00;
        repeat (30) tick();
        check("settle_lvl_a", lvl_o[0], 8'h00);
        check("settle_lvl_b", lvl_o[1], 8'h00);

        // Latency with D=4: ch0 level after edge 6, pulse for that cycle only
        in_v[1] = 8'h01;
        for (int k = 1; k <= 8; k++) begin
            tick();
            check($sformatf("lat_lvl_e%0d", k), lvl_o[1], (k >= 6) ? 8'h01 : 8'h00);
            check($sformatf("lat_rise_e%0d", k), rise_o[1], (k == 6) ? 8'h01 : 8'h00);
        end

        // Glitch rejection on the clip channel: 3-cycle pulses never pass a 4-cycle window
        repeat (10) begin
            in_v[1] = 8'h01 | (8'h01 << CH_CLIP);
            repeat (3) begin
                tick();
                check("glitch_lvl", lvl_o[1], 8'h01);
                check("glitch_rise", rise_o[1], 8'h00);
            end
            in_v[1] = 8'h01;
            repeat (3) begin
                tick();
                check("glitch_lvl", lvl_o[1], 8'h01);
                check("glitch_rise", rise_o[1], 8'h00);
            end
        end

        // Simultaneous rise on ch2 and fall on ch3
        in_v[1] = 8'h09;
        repeat (12) tick();
        check("sim_pre_lvl", lvl_o[1], 8'h09);
        in_v[1] = 8'h05;
        for (int k = 1; k <= 8; k++) begin
            tick();
            check($sformatf("sim_lvl_e%0d", k), lvl_o[1], (k >= 6) ? 8'h05 : 8'h09);
            check($sformatf("sim_rise_e%0d", k), rise_o[1], (k == 6) ? 8'h04 : 8'h00);
`ifdef FALL_PULSE_EN
            check($sformatf("sim_fall_e%0d", k), fall_o[1], (k == 6) ? 8'h08 : 8'h00);
`endif
        end

        // Reset in the middle of a count discards it
        in_v[0] = 8'h01;
        repeat (10) tick();
        check("mid_pre_lvl", lvl_o[0], 8'h00);
        #2 reset = 1'b0;
        tick();
        check("mid_rst_lvl_b", lvl_o[1], 8'h00);
        #2 reset = 1'b1;
        for (int k = 1; k <= 19; k++) begin
            tick();
            check($sformatf("mid_lvl_e%0d", k), lvl_o[0], (k >= 18) ? 8'h01 : 8'h00);
            check($sformatf("mid_rise_e%0d", k), rise_o[0], (k == 18) ? 8'h01 : 8'h00);
        end

        // Vector table on the 8-channel S=3 D=1 build
        in_v[2] = 8'h00;
        in_v[3] = 8'h00;
        repeat (8) tick();
        for (int r = 0; r < 13; r++) begin
            in_v[2] = tbl[r].in;
            tick();
            check($sformatf("tbl_lvl_r%0d", r), lvl_o[2], tbl[r].lvl);
            check($sformatf("tbl_rise_r%0d", r), rise_o[2], tbl[r].rise);
`ifdef FALL_PULSE_EN
            check($sformatf("tbl_fall_r%0d", r), fall_o[2], tbl[r].fall);
`endif
        end

        // Single-channel build follows after exactly 4 edges
        in_v[3] = 8'h01;
        for (int k = 1; k <= 5; k++) begin
            tick();
            check($sformatf("one_lvl_e%0d", k), lvl_o[3], (k >= 4) ? 8'h01 : 8'h00);
            check($sformatf("one_rise_e%0d", k), rise_o[3], (k == 4) ? 8'h01 : 8'h00);
        end

        // Randomized stimulus with hold times around each debounce window
        for (int d = 0; d < NDUT; d++) hold[d] = 0;
        repeat (3000) begin
            for (int d = 0; d < NDUT; d++) begin
                if (hold[d] == 0) begin
                    in_v[d] = 8'($urandom) & mask_of(W_P[d]);
                    hold[d] = $urandom_range(1, 2 * D_P[d] + 4);
                end else begin
                    hold[d] = hold[d] - 1;
                end
            end
            tick();
        end

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/button_sync_debounce.md
Name: button_sync_debounce

Overview:
- Parametrised successor to the per-button input synchroniser in the clip-recorder front end.
- Carries NUM_CH asynchronous push-button/switch inputs (reset button, clip number, play/record, action, ...) into the clock domain through a multi-flop synchroniser.
- Debounces each channel with a per-channel stability counter.
- Emits a clean level and a single-cycle rising-edge pulse per channel for the control FSM.

Parameters:
- NUM_CH, 4: number of independent input channels; legal range >= 1.
- SYNC_STAGES, 2: flip-flops in each synchroniser chain; legal range >= 2.
- DEBOUNCE_CYCLES, 16: consecutive cycles the synchronised input must differ from the current level before that level flips; legal range >= 1, where 1 means no filtering.

Ports:
- clock  input  1  single system clock; all state is updated on the rising edge.
- reset  input  1  asynchronous, active-low reset; assertion is asynchronous, deassertion is synchronous to clock.
- buttonsIn  input  NUM_CH  raw asynchronous inputs, one bit per channel.
- buttonsLevel  output  NUM_CH  debounced, synchronised level per channel; registered.
- buttonsRise  output  NUM_CH  one-cycle pulse on each 0->1 transition of buttonsLevel; registered.
- buttonsFall  output  NUM_CH  one-cycle pulse on each 1->0 transition of buttonsLevel; this port exists only when FALL_PULSE_EN is defined.

Behaviour:
- Reset (reset = 0): all synchroniser flops, counters, buttonsLevel, buttonsRise and buttonsFall are 0 immediately and asynchronously. Reset asserted mid-debounce discards any partial count.
- Synchroniser: per channel, a chain of SYNC_STAGES flops. syncd[i] is the last stage. Nothing else samples buttonsIn.
- Debounce, per channel, on each clock edge:
  - If syncd == level, then cnt <= 0.
  - Else if cnt == DEBOUNCE_CYCLES-1, then level <= syncd and cnt <= 0.
  - Else cnt <= cnt + 1.
- Counter width is CNT_W = max(1, $clog2(DEBOUNCE_CYCLES)). The counter never wraps, because it is cleared on reaching DEBOUNCE_CYCLES-1.
- Latency: a clean input change that is set up before edge 0 makes buttonsLevel change after edge SYNC_STAGES + DEBOUNCE_CYCLES.
- Glitch rejection: an input pulse that holds its new value for fewer than DEBOUNCE_CYCLES synchronised cycles produces no level change and no pulse. Any return to the current level clears the count.
- Pulses:
  - buttonsRise[i] is high for exactly the one cycle in which buttonsLevel[i] has just become 1, registered on the same edge as the level update.
  - buttonsRise[i] is never high on consecutive cycles, and is 0 during and immediately after reset.
- Channels are fully independent. Simultaneous transitions on several channels are each handled and pulsed in the same cycle.
- Toggling faster than the debounce window indefinitely keeps the level stable; there is no starvation-related output.
- Parameter checks: illegal parameter values trigger an elaboration-time $error.

Optional Feature:
- FALL_PULSE_EN defined:
  - Adds the buttonsFall port.
  - buttonsFall[i] is high for exactly one cycle when buttonsLevel[i] has just become 0.
  - buttonsFall[i] is 0 on reset and mutually exclusive with buttonsRise[i].
- FALL_PULSE_EN not defined:
  - The port and its logic are absent.
  - All other behaviour is identical.

Decomposition:
- Package button_sync_pkg holds:
  - Default constants DEF_SYNC_STAGES = 2 and DEF_DEBOUNCE_CYCLES = 16.
  - Channel index constants CH_RESET = 0, CH_CLIP = 1, CH_PLAYREC = 2, CH_ACTION = 3.
  - A CNT_W helper function.
- Sub-module debounce_channel handles one channel: synchroniser chain, counter, level, rise and fall registers.
- The top level instantiates debounce_channel NUM_CH times in a generate loop.

Test Plan:
- Reset check: hold reset low with buttonsIn = 4'b1111 -> all outputs 0 throughout. After release, with SYNC_STAGES = 2 and DEBOUNCE_CYCLES = 16, buttonsLevel = 4'b1111 after edge 18, and buttonsRise = 4'b1111 for one cycle.
- Latency check: SYNC_STAGES = 2, DEBOUNCE_CYCLES = 4, clean rise on ch0 before edge 0 -> buttonsLevel[0] = 1 after edge 6, buttonsRise[0] high only between edges 6 and 7.
- Glitch rejection: DEBOUNCE_CYCLES = 4, ch1 pulsed high for 3 cycles then low, repeated 10 times -> buttonsLevel[1] stays 0 and buttonsRise[1] never asserts.
- Simultaneous events: ch2 rises while ch3 falls in the same cycle with FALL_PULSE_EN -> after 6 edges, buttonsRise = 4'b0100 and buttonsFall = 4'b1000 in the same single cycle.
- Reset mid-count: DEBOUNCE_CYCLES = 16, ch0 high for 10 cycles, assert reset for 1 cycle, keep input high -> level rises only 18 edges after reset release, not earlier.
- Parameter sweep: NUM_CH = 1 and 8, DEBOUNCE_CYCLES = 1 and SYNC_STAGES = 3 -> level follows the input after exactly 4 edges, with one rise and one fall pulse per transition.
